// File: rtl/apb_spi_slave.sv
// apb_spi_slave: APB-attached SPI target, mode 0, MSB first, 8-bit frames.
// SPI pins are oversampled in the pclk domain; RX/TX FIFOs are exposed over APB.
// Optional build macro SPIS_IRQ_EN enables the level interrupt and CTRL[2:1].
module apb_spi_slave #(
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter logic [7:0]  TX_FILL  = 8'h00
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq
);

  localparam int unsigned RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW    = 5;

`ifdef SPIS_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b001;
`endif

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  // {sck, cs_n, mosi}; cs_n idles high so reset values avoid a false select
  logic [2:0]       pin_meta_q, pin_meta_d;
  logic [2:0]       pin_sync_q, pin_sync_d;
  logic [2:0]       pin_prev_q, pin_prev_d;

  state_e           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic             reload_q, reload_d;
  logic             miso_q, miso_d;
  logic             miso_oe_q, miso_oe_d;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       rx_mem_d [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;

  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       tx_mem_d [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;

  // {TX_OVF, TX_UDR, RX_OVR}
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             irq_q, irq_d;

  logic             sck_rise, sck_fall, cs_rise, cs_fall, cs_s, mosi_s;
  logic             acc, wr_acc, rd_acc;
  logic [1:0]       addr;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             spi_pop, rx_push, rx_pop, tx_push;
  logic [7:0]       rx_byte, pop_byte;
  logic [31:0]      rdata;

  logic unused_apb;
  assign unused_apb = ^{paddr[31:4], paddr[1:0], pwdata[31:8]};

  // Synchronizers and edge detectors for the asynchronous SPI pins
  always_comb begin
    pin_meta_d = {sck, cs_n, mosi};
    pin_sync_d = pin_meta_q;
    pin_prev_d = pin_sync_q;
    cs_s       = pin_sync_q[1];
    mosi_s     = pin_sync_q[0];
    sck_rise   = pin_sync_q[2] & ~pin_prev_q[2];
    sck_fall   = ~pin_sync_q[2] & pin_prev_q[2];
    cs_fall    = ~pin_sync_q[1] & pin_prev_q[1];
    cs_rise    = pin_sync_q[1] & ~pin_prev_q[1];
  end

  // Frame FSM, FIFOs, flags and APB register file next-state logic
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    reload_d  = reload_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    rx_mem_d  = rx_mem_q;
    rx_wr_d   = rx_wr_q;
    rx_rd_d   = rx_rd_q;
    rx_cnt_d  = rx_cnt_q;
    tx_mem_d  = tx_mem_q;
    tx_wr_d   = tx_wr_q;
    tx_rd_d   = tx_rd_q;
    tx_cnt_d  = tx_cnt_q;
    flags_d   = flags_q;
    ctrl_d    = ctrl_q;
    prdata_d  = prdata_q;
    spi_pop   = 1'b0;
    rx_push   = 1'b0;
    rx_byte   = {rx_sr_q[6:0], mosi_s};

    acc      = psel & penable & ~pready_q;
    wr_acc   = acc & pwrite;
    rd_acc   = acc & ~pwrite;
    addr     = paddr[3:2];
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == CW'(RX_DEPTH));
    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == CW'(TX_DEPTH));
    pop_byte = tx_empty ? TX_FILL : tx_mem_q[tx_rd_q];
    pready_d = acc;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0] && cs_fall) begin
          state_d   = ST_SHIFT;
          spi_pop   = 1'b1;
          miso_d    = pop_byte[7];
          tx_sr_d   = {pop_byte[6:0], 1'b0};
          miso_oe_d = 1'b1;
          bitcnt_d  = 3'd0;
          reload_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!ctrl_q[0] || cs_rise) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
          reload_d  = 1'b0;
          bitcnt_d  = 3'd0;
        end else if (sck_rise) begin
          rx_sr_d = rx_byte;
          if (bitcnt_q == 3'd7) begin
            rx_push  = 1'b1;
            bitcnt_d = 3'd0;
            reload_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else if (sck_fall) begin
          if (reload_q) begin
            spi_pop  = 1'b1;
            miso_d   = pop_byte[7];
            tx_sr_d  = {pop_byte[6:0], 1'b0};
            reload_d = 1'b0;
          end else begin
            miso_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // RX FIFO: SPI push, APB pop
    rx_pop = rd_acc && (addr == 2'd0) && !rx_empty;
    if (rx_push && !rx_full) begin
      rx_mem_d[rx_wr_q] = rx_byte;
      rx_wr_d = rx_wr_q + RX_AW'(1);
    end
    if (rx_pop) rx_rd_d = rx_rd_q + RX_AW'(1);
    case ({rx_push && !rx_full, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 5'd1;
      2'b01:   rx_cnt_d = rx_cnt_q - 5'd1;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    // TX FIFO: APB push, SPI pop
    tx_push = wr_acc && (addr == 2'd0) && !tx_full;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = pwdata[7:0];
      tx_wr_d = tx_wr_q + TX_AW'(1);
    end
    if (spi_pop && !tx_empty) tx_rd_d = tx_rd_q + TX_AW'(1);
    case ({tx_push, spi_pop && !tx_empty})
      2'b10:   tx_cnt_d = tx_cnt_q + 5'd1;
      2'b01:   tx_cnt_d = tx_cnt_q - 5'd1;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    // Sticky flags: clear first so a same-cycle set wins
    if (wr_acc && (addr == 2'd1)) flags_d = flags_q & ~pwdata[6:4];
    if (rx_push && rx_full)                       flags_d[0] = 1'b1;
    if (spi_pop && tx_empty)                      flags_d[1] = 1'b1;
    if (wr_acc && (addr == 2'd0) && tx_full)      flags_d[2] = 1'b1;

    if (wr_acc && (addr == 2'd2)) ctrl_d = pwdata[2:0] & CTRL_MASK;

    case (addr)
      2'd0:    rdata = {24'd0, rx_empty ? 8'h00 : rx_mem_q[rx_rd_q]};
      2'd1:    rdata = {24'd0, ~cs_s, flags_q, tx_full, tx_empty, rx_full, rx_empty};
      2'd2:    rdata = {29'd0, ctrl_q};
      default: rdata = {19'd0, tx_cnt_q, 3'd0, rx_cnt_q};
    endcase
    if (rd_acc) prdata_d = rdata;

`ifdef SPIS_IRQ_EN
    irq_d = (ctrl_q[1] & ~rx_empty) | (ctrl_q[2] & (|flags_q));
`else
    irq_d = 1'b0;
`endif
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      pin_meta_q <= 3'b010;
      pin_sync_q <= 3'b010;
      pin_prev_q <= 3'b010;
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      rx_sr_q    <= 8'd0;
      tx_sr_q    <= 8'd0;
      reload_q   <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      flags_q    <= 3'd0;
      ctrl_q     <= 3'd0;
      prdata_q   <= 32'd0;
      pready_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pin_meta_q <= pin_meta_d;
      pin_sync_q <= pin_sync_d;
      pin_prev_q <= pin_prev_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      reload_q   <= reload_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      flags_q    <= flags_d;
      ctrl_q     <= ctrl_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      irq_q      <= irq_d;
    end
  end

  // FIFO storage; occupancy is tracked by the reset counters
  always_ff @(posedge pclk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_apb_spi_slave.sv
// Directed bench for apb_spi_slave: APB register access plus a mode-0 SPI master model.
module tb_apb_spi_slave;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, sck, cs_n, mosi, miso, miso_oe, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int pready_bad = 0;

  logic [7:0]  mtx [16];
  logic [7:0]  mrx [16];
  logic [31:0] rd;

  apb_spi_slave #(.RX_DEPTH(8), .TX_DEPTH(8), .TX_FILL(8'h00)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int  waits;
    bit  seen;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0; seen = 1'b0; rdata = 32'd0;
    while (!seen && waits < 8) begin
      @(negedge pclk);
      waits++;
      if (pready) begin
        seen  = 1'b1;
        rdata = prdata;
      end
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL apb_timeout addr=0x%0h pready never high", addr);
    end
    if (waits != 1 || pready) pready_bad++;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data);
    apb_xfer(1'b0, addr, 32'd0, data);
  endtask

  // Mode 0 master, sck = pclk/8; miso sampled just before each rising edge
  task automatic spi_frame(input int n);
    cs_n = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        mosi = mtx[b][i];
        step(4);
        mrx[b][i] = miso;
        sck = 1'b1;
        step(4);
        sck = 1'b0;
      end
    end
    step(4);
    cs_n = 1'b1;
    step(8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    step(4);
    preset = 1'b0;
    step(1);

    // Reset state
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    apb_rd(32'h4, rd); check("rst_status", rd, 32'h05);
    apb_rd(32'hC, rd); check("rst_level", rd, 32'h0);

    // Basic exchange: 0xA5 out, 0x3C in
    apb_wr(32'h0, 32'hA5);
    apb_wr(32'h8, 32'h1);
    check("idle_oe", {31'd0, miso_oe}, 32'd0);
    mtx[0] = 8'h3C;
    spi_frame(1);
    check("m_rx_a5", {24'd0, mrx[0]}, 32'hA5);
    check("post_oe", {31'd0, miso_oe}, 32'd0);
    apb_rd(32'h0, rd); check("rx_3c", rd, 32'h3C);
    apb_rd(32'h4, rd); check("rx_empty_after", rd & 32'h1, 32'h1);
    apb_wr(32'h4, 32'h70);

    // Underrun: TX empty, two bytes
    mtx[0] = 8'h11; mtx[1] = 8'h22;
    spi_frame(2);
    check("udr_b0", {24'd0, mrx[0]}, 32'h00);
    check("udr_b1", {24'd0, mrx[1]}, 32'h00);
    apb_rd(32'h4, rd); check("udr_set", (rd >> 5) & 32'h1, 32'h1);
    apb_wr(32'h4, 32'h20);
    apb_rd(32'h4, rd); check("udr_clr", (rd >> 5) & 32'h1, 32'h0);
    apb_rd(32'h0, rd); check("rx_11", rd, 32'h11);
    apb_rd(32'h0, rd); check("rx_22", rd, 32'h22);

    // RX overrun: 9 bytes, no reads
    for (int i = 0; i < 9; i++) mtx[i] = 8'(i + 1);
    spi_frame(9);
    apb_rd(32'hC, rd); check("ovr_level", rd & 32'h1F, 32'd8);
    apb_rd(32'h4, rd);
    check("ovr_full", (rd >> 1) & 32'h1, 32'h1);
    check("ovr_flag", (rd >> 4) & 32'h1, 32'h1);
    for (int i = 0; i < 8; i++) begin
      apb_rd(32'h0, rd); check("ovr_order", rd, 32'(i + 1));
    end
    apb_rd(32'h0, rd); check("ovr_9th_absent", rd, 32'h0);
    apb_wr(32'h4, 32'h70);

    // Aborted frame: 5 sck edges then deselect
    cs_n = 1'b0; mosi = 1'b1;
    step(4);
    check("mid_oe", {31'd0, miso_oe}, 32'd1);
    sck = 1'b1; step(4); sck = 1'b0; step(4);
    sck = 1'b1; step(4); sck = 1'b0; step(4);
    sck = 1'b1; step(4);
    cs_n = 1'b1; step(4); sck = 1'b0; step(8);
    apb_rd(32'hC, rd); check("abort_level", rd & 32'h1F, 32'd0);
    mtx[0] = 8'h7E;
    spi_frame(1);
    apb_rd(32'h0, rd); check("rx_7e", rd, 32'h7E);
    apb_wr(32'h4, 32'h70);

    // TX overflow: 9 writes into 8 entries
    for (int i = 0; i < 9; i++) apb_wr(32'h0, 32'(8'h10 + i));
    apb_rd(32'h4, rd);
    check("tx_full", (rd >> 3) & 32'h1, 32'h1);
    check("tx_ovf", (rd >> 6) & 32'h1, 32'h1);
    apb_rd(32'hC, rd); check("tx_level", (rd >> 8) & 32'h1F, 32'd8);
    check("pready_1cyc", 32'(pready_bad), 32'd0);
    for (int i = 0; i < 8; i++) mtx[i] = 8'hF0;
    spi_frame(8);
    for (int i = 0; i < 8; i++) check("tx_order", {24'd0, mrx[i]}, 32'(8'h10 + i));
    apb_rd(32'hC, rd); check("tx_drain_level", rd, 32'h0008);

    // Reset mid-frame
    apb_wr(32'h0, 32'h99);
    cs_n = 1'b0; mosi = 1'b1;
    step(4); sck = 1'b1; step(4); sck = 1'b0; step(2);
    preset = 1'b1;
    step(1);
    check("mrst_prdata", prdata, 32'd0);
    check("mrst_pready", {31'd0, pready}, 32'd0);
    check("mrst_miso", {31'd0, miso}, 32'd0);
    check("mrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("mrst_irq", {31'd0, irq}, 32'd0);
    cs_n = 1'b1; step(2);
    preset = 1'b0;
    step(8);
    apb_rd(32'hC, rd); check("mrst_level", rd, 32'h0);
    apb_rd(32'h8, rd); check("mrst_ctrl", rd, 32'h0);
    apb_rd(32'h4, rd); check("mrst_status", rd, 32'h05);

    // Interrupt behaviour
`ifdef SPIS_IRQ_EN
    apb_wr(32'h8, 32'h3);
    apb_rd(32'h8, rd); check("irq_ctrl", rd, 32'h3);
    check("irq_idle", {31'd0, irq}, 32'd0);
    mtx[0] = 8'h55;
    spi_frame(1);
    check("irq_set", {31'd0, irq}, 32'd1);
    apb_rd(32'h0, rd); check("irq_rx_55", rd, 32'h55);
    step(2);
    check("irq_clr", {31'd0, irq}, 32'd0);
`else
    apb_wr(32'h8, 32'h7);
    apb_rd(32'h8, rd); check("ctrl_mask", rd, 32'h1);
    mtx[0] = 8'h55;
    spi_frame(1);
    check("irq_tied", {31'd0, irq}, 32'd0);
    apb_rd(32'h0, rd); check("rx_55", rd, 32'h55);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_spi_slave.md
Name: apb_spi_slave

Overview:
APB-attached SPI target (slave) peripheral. It is the responder end of the SPI link driven by the team's SPI master peripherals: an external or on-chip master drives sck/cs_n/mosi, and this block returns miso. Received bytes go into an RX FIFO that software reads over APB; software preloads the bytes to be returned into a TX FIFO. Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. SPI inputs are oversampled in the pclk domain.

Parameters:
RX_DEPTH, 8, RX FIFO entries; power of 2, range 2..16
TX_DEPTH, 8, TX FIFO entries; power of 2, range 2..16
TX_FILL, 8'h00, byte shifted out on TX underrun

Ports:
pclk  in  1  APB clock; the single clock of the block
preset  in  1  synchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  32  APB address; only [3:2] decoded
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready
sck  in  1  SPI clock from master (async)
cs_n  in  1  SPI chip select, active low (async)
mosi  in  1  SPI data from master (async)
miso  out  1  SPI data to master
miso_oe  out  1  miso output enable (high only while selected and EN=1)
irq  out  1  level interrupt

Behaviour:
- Reset (preset=1 at a pclk edge): prdata=0, pready=0, miso=0, miso_oe=0, irq=0. FIFOs empty, sticky flags 0, CTRL=0, bit counter 0. Applies mid-frame; the partial frame is lost.
- APB: one wait state. In the first access-phase cycle (psel&penable&!pready), register pready=1 for exactly one cycle, then 0. Read data and side effects commit in that same cycle, once per transfer. No pslverr.
- Register map (paddr[3:2]):
  - 0x00 DATA. W: push pwdata[7:0] to the TX FIFO. If TX is full, the byte is dropped and TX_OVF is set. R: pop the RX FIFO and return the byte in [7:0]. If RX is empty, return 0 with no pop.
  - 0x04 STATUS. R: [0] RX_EMPTY, [1] RX_FULL, [2] TX_EMPTY, [3] TX_FULL, [4] RX_OVR, [5] TX_UDR, [6] TX_OVF, [7] CS_ACTIVE. W: write 1 to clear bits [6:4].
  - 0x08 CTRL (R/W). [0] EN, [1] IRQ_RX_EN, [2] IRQ_ERR_EN.
  - 0x0C LEVEL (R). [4:0] RX count, [12:8] TX count.
  - Unused register bits read 0.
- Input sync: sck, cs_n and mosi each pass through a 2-flop synchronizer, then an edge-detect register. pclk must be at least 4x sck.
- Frame state machine. States IDLE, SHIFT.
  - IDLE -> SHIFT on detected cs_n fall with EN=1. On entry: pop TX (TX_FILL if empty, and set TX_UDR), drive the MSB on miso, set miso_oe=1, bitcnt=0.
  - SHIFT, sck rise: shift mosi into rx_sr LSB and increment bitcnt.
  - On the 8th rise: push the byte into RX. If RX is full, drop the byte and set RX_OVR. RX_EMPTY deasserts no later than 4 pclk after the 8th sck rise at the pin. bitcnt returns to 0 and a reload is marked.
  - SHIFT, sck fall: if reload is marked, pop the next TX byte (underrun handled as above) and drive its MSB. Otherwise shift the next bit out.
  - SHIFT -> IDLE on detected cs_n rise, or when EN is cleared. The partial RX byte is discarded and not pushed, and miso_oe=0. The TX byte already popped is consumed.
- Simultaneous events: an APB pop and an SPI push of RX in the same cycle both take effect, and the count is unchanged. The same holds for an APB push and an SPI pop of TX. A W1C in the same cycle as a new flag set leaves the flag set.
- EN=0: SPI pins are ignored and miso_oe=0. FIFOs and APB access still work.

Optional Feature:
SPIS_IRQ_EN:
- Defined: irq = (IRQ_RX_EN & !RX_EMPTY) | (IRQ_ERR_EN & (RX_OVR|TX_UDR|TX_OVF)), registered, asserting 1 pclk after the condition. CTRL[2:1] are writable.
- Undefined: irq tied 0, and CTRL[2:1] read 0 and ignore writes.

Test Plan:
- Preload TX 0xA5, EN=1; master sends 0x3C mode 0 with sck=pclk/8 -> master receives 0xA5; DATA read returns 0x3C; STATUS RX_EMPTY=1 afterwards.
- TX empty, master clocks 2 bytes 0x11, 0x22 -> master receives 0x00, 0x00; TX_UDR=1; writing 0x20 to STATUS clears it.
- Master sends RX_DEPTH+1 bytes with no reads -> first 8 bytes read back in order; RX_OVR=1; 9th byte absent.
- cs_n deasserted after 5 sck edges -> RX count stays 0; next full frame 0x7E received correctly.
- APB write 9 bytes with TX_DEPTH=8 -> TX_FULL=1, TX_OVF=1, LEVEL[12:8]=8; every APB access shows pready high exactly one cycle.
- preset pulsed mid-frame -> all outputs 0, LEVEL=0, CTRL=0; SPIS_IRQ_EN build: IRQ_RX_EN=1 plus one received byte -> irq=1 until DATA read.
